// File: rtl/sram_multi_port_param_if.sv
// Bus bundle for sram_multi_port_param: packed write/read port groups plus status outputs.
// The master drives writes and read requests; the slave (the SRAM) returns data and status.
interface sram_multi_port_param_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_W_PORTS = 2,
    parameter int NUM_R_PORTS = 2,
    parameter int CNT_WIDTH   = 16
);
    logic [NUM_W_PORTS*DATA_WIDTH-1:0] W_Data_In;
    logic [NUM_W_PORTS*ADDR_WIDTH-1:0] W_Address_In;
    logic [NUM_W_PORTS-1:0]            W_Enable_In;
    logic [NUM_R_PORTS*ADDR_WIDTH-1:0] R_Address_In;
    logic [NUM_R_PORTS-1:0]            R_Enable_In;
    logic [NUM_R_PORTS*DATA_WIDTH-1:0] R_Data_Out;
    logic [NUM_R_PORTS-1:0]            R_Valid_Out;
    logic                              Init_Done_Out;
    logic                              Collision_Out;
    logic [CNT_WIDTH-1:0]              Collision_Count_Out;

    modport master (
        output W_Data_In, W_Address_In, W_Enable_In, R_Address_In, R_Enable_In,
        input  R_Data_Out, R_Valid_Out, Init_Done_Out, Collision_Out, Collision_Count_Out
    );

    modport slave (
        input  W_Data_In, W_Address_In, W_Enable_In, R_Address_In, R_Enable_In,
        output R_Data_Out, R_Valid_Out, Init_Done_Out, Collision_Out, Collision_Count_Out
    );
endinterface

// File: rtl/sram_multi_port_param.sv
// Parametrised multi-port SRAM with clear-on-reset sweep, lowest-index-wins write arbitration
// and a saturating collision counter. Define MPRAM_BYPASS_EN for write-first read forwarding.
module sram_multi_port_param #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_W_PORTS = 2,
    parameter int NUM_R_PORTS = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    Clk_In,
    input  logic                    Reset_In,
    sram_multi_port_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                            state, state_nxt;
    logic [ADDR_WIDTH-1:0]             sweep_ptr, sweep_ptr_nxt;
    logic [DATA_WIDTH-1:0]             mem [DEPTH];
    logic [NUM_W_PORTS-1:0]            w_win;
    logic                              collision;
    logic [NUM_R_PORTS*DATA_WIDTH-1:0] r_word;
    logic                              ready;

    assign ready             = (state == ST_READY);
    assign bus.Init_Done_Out = ready;

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state     <= ST_CLEAR;
            sweep_ptr <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        if (state == ST_CLEAR) begin
            sweep_ptr_nxt = sweep_ptr + ADDR_WIDTH'(1);
            if (&sweep_ptr) state_nxt = ST_READY;
        end
    end

    // A port wins unless a lower-index enabled port targets the same address.
    always_comb begin
        w_win     = '0;
        collision = 1'b0;
        if (ready) begin
            for (int unsigned k = 0; k < NUM_W_PORTS; k++) begin
                w_win[k] = bus.W_Enable_In[k];
                for (int unsigned i = 0; i < k; i++) begin
                    if (bus.W_Enable_In[i] && bus.W_Enable_In[k] &&
                        bus.W_Address_In[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                        bus.W_Address_In[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        w_win[k]  = 1'b0;
                        collision = 1'b1;
                    end
                end
            end
        end
    end

    // Winners have distinct addresses, so the write loop order is irrelevant.
    always_ff @(posedge Clk_In) begin
        if (state == ST_CLEAR) begin
            mem[sweep_ptr] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_W_PORTS; k++) begin
                if (w_win[k])
                    mem[bus.W_Address_In[k*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        bus.W_Data_In[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        r_word = '0;
        for (int unsigned j = 0; j < NUM_R_PORTS; j++) begin
            r_word[j*DATA_WIDTH +: DATA_WIDTH] = mem[bus.R_Address_In[j*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef MPRAM_BYPASS_EN
            for (int unsigned k = 0; k < NUM_W_PORTS; k++) begin
                if (w_win[k] && bus.W_Address_In[k*ADDR_WIDTH +: ADDR_WIDTH] ==
                                bus.R_Address_In[j*ADDR_WIDTH +: ADDR_WIDTH])
                    r_word[j*DATA_WIDTH +: DATA_WIDTH] = bus.W_Data_In[k*DATA_WIDTH +: DATA_WIDTH];
            end
`endif
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            bus.R_Data_Out          <= '0;
            bus.R_Valid_Out         <= '0;
            bus.Collision_Out       <= 1'b0;
            bus.Collision_Count_Out <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_R_PORTS; j++) begin
                bus.R_Valid_Out[j] <= ready && bus.R_Enable_In[j];
                if (ready && bus.R_Enable_In[j])
                    bus.R_Data_Out[j*DATA_WIDTH +: DATA_WIDTH] <= r_word[j*DATA_WIDTH +: DATA_WIDTH];
            end
            bus.Collision_Out <= collision;
            if (collision && !(&bus.Collision_Count_Out))
                bus.Collision_Count_Out <= bus.Collision_Count_Out + CNT_WIDTH'(1);
        end
    end
endmodule
